// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller: condition codes,
// controller state encoding and the branch-history counter reset value.
// Imported by branch_cmp and branch_resolve_ctrl.
package branch_pkg;

    // Branch condition codes carried in funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // History counters start weakly not-taken
    localparam logic [1:0] BHT_RESET = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EVAL     = 2'b01,
        REDIRECT = 2'b10
    } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: operands + funct3 -> taken.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rs1_d/rs2_d operands, funct3 condition code, taken outcome.
import branch_pkg::*;

module branch_cmp (
    input  logic [31:0] rs1_d,
    input  logic [31:0] rs2_d,
    input  logic [2:0]  funct3,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1_d == rs2_d);
            F3_BNE:  taken = (rs1_d != rs2_d);
            F3_BLT:  taken = ($signed(rs1_d) <  $signed(rs2_d));
            F3_BGE:  taken = ($signed(rs1_d) >= $signed(rs2_d));
            F3_BLTU: taken = (rs1_d <  rs2_d);
            F3_BGEU: taken = (rs1_d >= rs2_d);
            default: taken = 1'b0;   // 010/011 are not branch conditions
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: evaluates one branch at a time, reports the
// outcome, and issues a fetch redirect on mispredict.
// Latency: resolve_valid one cycle after acceptance; redirect follows in the next cycle.
// Backpressure: req_ready only in IDLE; redirect held until redirect_ready; flush aborts.
// Ports: clk/rst (async active-low); req_* branch request (valid/ready);
//   resolve_* + exc_misalign outcome pulse; redirect_* fetch redirect (valid/ready);
//   pred_pc -> pred_taken fetch-side prediction lookup; mispredict_cnt saturating count.
// Build option: define BRANCH_PREDICT_EN to include the 2-bit counter history table;
//   otherwise pred_taken is tied low.
import branch_pkg::*;

module branch_resolve_ctrl #(
    parameter int BHT_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_imm,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1_d,
    input  logic [31:0] req_rs2_d,
    input  logic        req_pred_taken,
    input  logic        flush,
    output logic        resolve_valid,
    output logic        resolve_taken,
    output logic [31:0] resolve_target,
    output logic        exc_misalign,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic [15:0] mispredict_cnt
);

    state_t      state, state_nx;

    logic [31:0] pc_q, imm_q, rs1_q, rs2_q;
    logic [2:0]  funct3_q;
    logic        pred_q;

    logic        taken;
    logic [31:0] target, fallthrough;
    logic        misalign, mispredict;
    logic        accept, redir_load, redir_done;
    logic [31:0] redirect_pc_q;
    logic [15:0] cnt_q;

    branch_cmp u_cmp (
        .rs1_d  (rs1_q),
        .rs2_d  (rs2_q),
        .funct3 (funct3_q),
        .taken  (taken)
    );

    assign target      = pc_q + imm_q;
    assign fallthrough = pc_q + 32'd4;
    assign misalign    = taken && (target[1:0] != 2'b00);
    // A misaligned taken branch raises an exception instead of redirecting
    assign mispredict  = (taken != pred_q) && !misalign;

    always_comb begin
        state_nx       = state;
        req_ready      = 1'b0;
        resolve_valid  = 1'b0;
        redirect_valid = 1'b0;
        accept         = 1'b0;
        redir_load     = 1'b0;
        redir_done     = 1'b0;
        case (state)
            IDLE: begin
                // A flush in IDLE has nothing to abort but still blocks acceptance
                req_ready = !flush;
                if (req_valid && !flush) begin
                    accept   = 1'b1;
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    resolve_valid = 1'b1;
                    if (mispredict) begin
                        redir_load = 1'b1;
                        state_nx   = REDIRECT;
                    end else begin
                        state_nx   = IDLE;
                    end
                end
            end
            REDIRECT: begin
                // Flush wins over a same-cycle redirect_ready
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    redirect_valid = 1'b1;
                    if (redirect_ready) begin
                        redir_done = 1'b1;
                        state_nx   = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            funct3_q      <= '0;
            pred_q        <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pc_q     <= req_pc;
                imm_q    <= req_imm;
                rs1_q    <= req_rs1_d;
                rs2_q    <= req_rs2_d;
                funct3_q <= req_funct3;
                pred_q   <= req_pred_taken;
            end
            if (redir_load) begin
                redirect_pc_q <= taken ? target : fallthrough;
            end
            if (redir_done && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Outcome flags are qualified so they read zero outside the resolve pulse;
    // the target reads zero after reset because the captured fields are cleared.
    assign resolve_taken  = resolve_valid & taken;
    assign exc_misalign   = resolve_valid & misalign;
    assign resolve_target = target;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;

`ifdef BRANCH_PREDICT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] upd_idx, look_idx;

    assign upd_idx  = pc_q[BHT_IDX_W+1:2];
    assign look_idx = pred_pc[BHT_IDX_W+1:2];

    // Lookup reads the array register, so a same-cycle update is not visible yet
    assign pred_taken = bht[look_idx][1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= BHT_RESET;
            end
        end else if (resolve_valid) begin
            if (taken && (bht[upd_idx] != 2'b11)) begin
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else if (!taken && (bht[upd_idx] != 2'b00)) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end
`else
    assign pred_taken = 1'b0;
`endif

    // Address bits outside the table index are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^pred_pc;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic [31:0] req_imm = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_rs1_d = '0;
    logic [31:0] req_rs2_d = '0;
    logic        req_pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        exc_misalign;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc;
    logic [31:0] pred_pc = '0;
    logic        pred_taken;
    logic [15:0] mispredict_cnt;

    branch_resolve_ctrl #(.BHT_IDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .req_imm        (req_imm),
        .req_funct3     (req_funct3),
        .req_rs1_d      (req_rs1_d),
        .req_rs2_d      (req_rs2_d),
        .req_pred_taken (req_pred_taken),
        .flush          (flush),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .exc_misalign   (exc_misalign),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          bht_m [16];
    logic [15:0] cnt_m = '0;

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: outcome straight from the condition-code table
    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
        return bht_m[bidx(pc)] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_bht_update(input logic [31:0] pc, input logic tk);
        int i;
        i = bidx(pc);
        if (tk) bht_m[i] = (bht_m[i] == 3) ? 3 : bht_m[i] + 1;
        else    bht_m[i] = (bht_m[i] == 0) ? 0 : bht_m[i] - 1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
        cnt_m = '0;
    endtask

    // Present one request in IDLE; returns at the negedge where the DUT is in EVAL
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
        @(negedge clk);
        req_pc = pc; req_imm = imm; req_funct3 = f3;
        req_rs1_d = a; req_rs2_d = b; req_pred_taken = pred;
        req_valid = 1'b1; pred_pc = pc;
        #1;
        check1("req_ready_idle", req_ready, 1'b1);
        check1("pred_lookup", pred_taken, model_pred(pc));
        @(negedge clk);
        req_valid = 1'b0;
        // scramble inputs so the DUT must be using its captured copy
        req_pc = $urandom; req_imm = $urandom; req_rs1_d = $urandom; req_rs2_d = $urandom;
        req_funct3 = 3'($urandom); req_pred_taken = 1'($urandom);
        #1;
    endtask

    task automatic run_branch(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b, input logic pred,
                              input int delay);
        logic tk, ms, rd;
        logic [31:0] tgt, rpc;
        tgt = pc + imm;
        tk  = model_taken(f3, a, b);
        ms  = tk && (tgt[1:0] != 2'b00);
        rd  = !ms && (tk != pred);
        rpc = tk ? tgt : pc + 32'd4;
        issue(pc, imm, f3, a, b, pred);
        check1("resolve_valid", resolve_valid, 1'b1);
        check1("resolve_taken", resolve_taken, tk);
        check32("resolve_target", resolve_target, tgt);
        check1("exc_misalign", exc_misalign, ms);
        check1("req_ready_eval", req_ready, 1'b0);
        check1("redirect_valid_eval", redirect_valid, 1'b0);
        check1("pred_same_cycle", pred_taken, model_pred(pc));
        model_bht_update(pc, tk);
        if (rd) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk); redirect_ready = 1'b0; #1;
                check1("redirect_hold_valid", redirect_valid, 1'b1);
                check32("redirect_hold_pc", redirect_pc, rpc);
                check1("resolve_single_pulse", resolve_valid, 1'b0);
            end
            @(negedge clk); redirect_ready = 1'b1; #1;
            check1("redirect_valid", redirect_valid, 1'b1);
            check32("redirect_pc", redirect_pc, rpc);
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            @(negedge clk); redirect_ready = 1'b0; #1;
        end else begin
            @(negedge clk); #1;
        end
        check1("back_idle", req_ready, 1'b1);
        check1("no_redirect", redirect_valid, 1'b0);
        check1("no_resolve_idle", resolve_valid, 1'b0);
        check32("mispredict_cnt", {16'h0, mispredict_cnt}, {16'h0, cnt_m});
    endtask

    logic [31:0] ops [5];

    initial begin
        ops[0] = 32'h0; ops[1] = 32'h1; ops[2] = 32'hFFFF_FFFF; ops[3] = 32'h8000_0000; ops[4] = 32'h5;
        model_reset();

        // Reset state
        #12;
        check1("rst_resolve_valid", resolve_valid, 1'b0);
        check1("rst_resolve_taken", resolve_taken, 1'b0);
        check32("rst_resolve_target", resolve_target, 32'h0);
        check1("rst_exc", exc_misalign, 1'b0);
        check1("rst_redirect_valid", redirect_valid, 1'b0);
        check32("rst_redirect_pc", redirect_pc, 32'h0);
        check32("rst_cnt", {16'h0, mispredict_cnt}, 32'h0);
        check1("rst_pred", pred_taken, 1'b0);
        @(negedge clk); rst = 1'b1;

        // BEQ taken, correctly predicted
        run_branch(32'h100, 32'h20, 3'b000, 32'd5, 32'd5, 1'b1, 0);
        // BLT taken, predicted not taken, redirect held 3 cycles
        run_branch(32'h100, 32'h20, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 3);
        check32("cnt_after_blt", {16'h0, mispredict_cnt}, 32'd1);
        // BLTU not taken, predicted taken, fallthrough wraps to zero
        run_branch(32'hFFFF_FFFC, 32'h20, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1);
        // BNE taken to misaligned target: exception, no redirect
        run_branch(32'h100, 32'h22, 3'b001, 32'd1, 32'd2, 1'b0, 0);

        // Flush during EVAL: no pulse, no table/counter change
        issue(32'h40, 32'h8, 3'b000, 32'd0, 32'd0, 1'b0);
        flush = 1'b1; #1;
        check1("flush_eval_no_resolve", resolve_valid, 1'b0);
        check1("flush_eval_no_redirect", redirect_valid, 1'b0);
        @(negedge clk); flush = 1'b0; #1;
        check1("flush_eval_idle", req_ready, 1'b1);
        check1("flush_eval_no_late_pulse", resolve_valid, 1'b0);
        check1("flush_eval_bht", pred_taken, model_pred(32'h40));
        check32("flush_eval_cnt", {16'h0, mispredict_cnt}, {16'h0, cnt_m});

        // Flush in REDIRECT together with redirect_ready: flush wins
        issue(32'h200, 32'h10, 3'b000, 32'd7, 32'd7, 1'b0);
        model_bht_update(32'h200, 1'b1);
        @(negedge clk); redirect_ready = 1'b1; flush = 1'b1; #1;
        check1("flush_redir_no_valid", redirect_valid, 1'b0);
        check32("flush_redir_pc", redirect_pc, 32'h210);
        @(negedge clk); redirect_ready = 1'b0; flush = 1'b0; #1;
        check1("flush_redir_idle", req_ready, 1'b1);
        check1("flush_redir_no_valid_after", redirect_valid, 1'b0);
        check32("flush_redir_cnt", {16'h0, mispredict_cnt}, {16'h0, cnt_m});

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'b000; req_rs1_d = 0; req_rs2_d = 0;
        #1;
        check1("flush_idle_ready", req_ready, 1'b0);
        @(negedge clk); req_valid = 1'b0; flush = 1'b0; #1;
        check1("flush_idle_not_accepted", resolve_valid, 1'b0);
        check1("flush_idle_still_idle", req_ready, 1'b1);

        // Asynchronous reset while in EVAL (redirect_pc currently nonzero)
        issue(32'h300, 32'h40, 3'b001, 32'd1, 32'd2, 1'b0);
        rst = 1'b0; #1;
        model_reset();
        check1("mid_rst_resolve_valid", resolve_valid, 1'b0);
        check1("mid_rst_resolve_taken", resolve_taken, 1'b0);
        check32("mid_rst_target", resolve_target, 32'h0);
        check1("mid_rst_exc", exc_misalign, 1'b0);
        check1("mid_rst_redirect_valid", redirect_valid, 1'b0);
        check32("mid_rst_redirect_pc", redirect_pc, 32'h0);
        check32("mid_rst_cnt", {16'h0, mispredict_cnt}, 32'h0);
        @(negedge clk); rst = 1'b1; #1;
        check1("post_rst_idle", req_ready, 1'b1);

        // Repeated taken branches at one PC train and saturate the counter
        for (int k = 0; k < 4; k++) begin
            run_branch(32'h40, 32'h8, 3'b000, 32'd3, 32'd3, 1'b1, 0);
        end
        pred_pc = 32'h40; #1;
`ifdef BRANCH_PREDICT_EN
        check1("bht_trained", pred_taken, 1'b1);
`else
        check1("bht_absent", pred_taken, 1'b0);
`endif
        run_branch(32'h40, 32'h8, 3'b001, 32'd3, 32'd3, 1'b0, 0);
        pred_pc = 32'h40; #1;
        check1("bht_after_saturate", pred_taken, model_pred(32'h40));

        // Randomized branches against the reference model
        for (int n = 0; n < 40; n++) begin
            run_branch(32'h1000 + (32'($urandom_range(0, 7)) << 2),
                       (32'($urandom_range(0, 31)) << 1) - 32'd32,
                       3'($urandom_range(0, 7)),
                       ops[$urandom_range(0, 4)],
                       ops[$urandom_range(0, 4)],
                       1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
